// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, next-PC selection from the decode-stage
// redirect, and the IF/ID pipeline register feeding decode.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] NOP      = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        clr_D,
   input  logic [1:0]  npc_sel,
   input  logic [15:0] imm16_D,
   input  logic [25:0] imm26_D,
   input  logic [31:0] rs_val_D,
   output logic [31:0] pc_F,
   input  logic [31:0] instr_F,
   output logic [31:0] instr_D,
   output logic [31:0] pc_D,
   output logic [31:0] pc8_D
);

   typedef enum logic [1:0] {
      NPC_SEQ    = 2'd0,
      NPC_BRANCH = 2'd1,
      NPC_JUMP   = 2'd2,
      NPC_JR     = 2'd3
   } npc_sel_t;

   npc_sel_t    sel;
   logic [31:0] seq_pc;
   logic [31:0] branch_off;
   logic [31:0] branch_pc;
   logic [31:0] jump_pc;
   logic [31:0] jr_pc;
   logic [31:0] next_pc;

   assign sel = npc_sel_t'(npc_sel);

   // Redirect targets are relative to the instruction in D, not to the delay slot in F;
   // all arithmetic wraps modulo 2^32.
   always_comb begin
      seq_pc     = pc_F + 32'd4;
      branch_off = {{14{imm16_D[15]}}, imm16_D, 2'b00};
      branch_pc  = pc_D + 32'd4 + branch_off;
      jump_pc    = (pc_D & 32'hF000_0000) | {4'b0000, imm26_D, 2'b00};
      jr_pc      = rs_val_D & 32'hFFFF_FFFC;
      next_pc    = seq_pc;
      unique case (sel)
         NPC_SEQ:    next_pc = seq_pc;
         NPC_BRANCH: next_pc = branch_pc;
         NPC_JUMP:   next_pc = jump_pc;
         NPC_JR:     next_pc = jr_pc;
         default:    next_pc = seq_pc;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_F <= RESET_PC;
      end else if (!stall) begin
         pc_F <= next_pc;
      end
   end

   // Clear squashes only the word, the PC of the bubble still tracks the fetch address.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr_D <= NOP;
         pc_D    <= RESET_PC;
      end else if (!stall) begin
         instr_D <= clr_D ? NOP : instr_F;
         pc_D    <= pc_F;
      end
   end

   assign pc8_D = pc_D + 32'd8;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized run
// compared against a cycle-level reference model of the fetch stage.
module tb_if_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam logic [31:0] NOP      = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        clr_D;
   logic [1:0]  npc_sel;
   logic [15:0] imm16_D;
   logic [25:0] imm26_D;
   logic [31:0] rs_val_D;
   logic [31:0] pc_F;
   logic [31:0] instr_F;
   logic [31:0] instr_D;
   logic [31:0] pc_D;
   logic [31:0] pc8_D;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] m_pc;
   logic [31:0] m_pcd;
   logic [31:0] m_instr;

   if_stage #(.RESET_PC(RESET_PC), .NOP(NOP)) dut (
      .clk(clk), .reset(reset), .stall(stall), .clr_D(clr_D), .npc_sel(npc_sel),
      .imm16_D(imm16_D), .imm26_D(imm26_D), .rs_val_D(rs_val_D), .pc_F(pc_F),
      .instr_F(instr_F), .instr_D(instr_D), .pc_D(pc_D), .pc8_D(pc8_D)
   );

   always #5 clk = ~clk;

   // Address-tagged instruction memory: every address returns a distinct word.
   function automatic logic [31:0] imem(input logic [31:0] addr);
      return (addr * 32'h9E37_79B1) + 32'h1234_5678;
   endfunction

   assign instr_F = imem(pc_F);

   task automatic set_idle();
      stall = 0; clr_D = 0; npc_sel = 0; imm16_D = 0; imm26_D = 0; rs_val_D = 0;
   endtask

   // One rising edge, with the reference model advanced from the stage's rules.
   task automatic tick();
      logic [31:0] target;
      int          off;
      @(posedge clk);
      if (!stall) begin
         off = $signed(imm16_D);
         case (npc_sel)
            2'd0: target = m_pc + 32'd4;
            2'd1: target = m_pcd + 32'd4 + 32'(off * 4);
            2'd2: target = (m_pcd & 32'hF000_0000) + 32'(imm26_D) * 32'd4;
            default: target = rs_val_D - (rs_val_D % 32'd4);
         endcase
         m_instr = clr_D ? NOP : imem(m_pc);
         m_pcd   = m_pc;
         m_pc    = target;
      end
      #1;
   endtask

   task automatic do_reset();
      set_idle();
      reset = 0;
      m_pc = RESET_PC; m_pcd = RESET_PC; m_instr = NOP;
      @(posedge clk);
      #1;
      reset = 1;
   endtask

   task automatic advance_to_pcd(input logic [31:0] target);
      npc_sel = 0;
      for (int i = 0; i < 64 && m_pcd != target; i++) tick();
   endtask

   task automatic test_reset();
      set_idle();
      reset = 0;
      m_pc = RESET_PC; m_pcd = RESET_PC; m_instr = NOP;
      @(posedge clk);
      #1;
      n_checks++;
      if ({pc_F, instr_D, pc_D, pc8_D} !== {RESET_PC, NOP, RESET_PC, RESET_PC + 32'd8}) begin
         n_fail++;
         $display("[TB] FAIL reset_values: got %h %h %h %h want %h %h %h %h",
                  pc_F, instr_D, pc_D, pc8_D, RESET_PC, NOP, RESET_PC, RESET_PC + 32'd8);
      end
      reset = 1;
      #1;
      n_checks++;
      if (pc_F !== RESET_PC) begin
         n_fail++;
         $display("[TB] FAIL release_pc: got %h want %h", pc_F, RESET_PC);
      end
   endtask

   task automatic test_sequential();
      tick();
      n_checks++;
      if ({pc_F, instr_D, pc_D, pc8_D} !== {32'h3004, imem(32'h3000), 32'h3000, 32'h3008}) begin
         n_fail++;
         $display("[TB] FAIL first_fetch: got %h %h %h %h want %h %h %h %h",
                  pc_F, instr_D, pc_D, pc8_D, 32'h3004, imem(32'h3000), 32'h3000, 32'h3008);
      end
      tick();
      n_checks++;
      if ({pc_F, instr_D, pc_D, pc8_D} !== {32'h3008, imem(32'h3004), 32'h3004, 32'h300C}) begin
         n_fail++;
         $display("[TB] FAIL second_fetch: got %h %h %h %h want %h %h %h %h",
                  pc_F, instr_D, pc_D, pc8_D, 32'h3008, imem(32'h3004), 32'h3004, 32'h300C);
      end
   endtask

   task automatic test_branch(input logic [15:0] imm, input logic [31:0] want_pc, input string name);
      do_reset();
      advance_to_pcd(32'h3010);
      npc_sel = 1; imm16_D = imm;
      tick();
      n_checks++;
      if ({pc_F, instr_D, pc_D} !== {want_pc, imem(32'h3014), 32'h3014}) begin
         n_fail++;
         $display("[TB] FAIL %s_delay_slot: got %h %h %h want %h %h %h",
                  name, pc_F, instr_D, pc_D, want_pc, imem(32'h3014), 32'h3014);
      end
      npc_sel = 0; imm16_D = 0;
      tick();
      n_checks++;
      if ({instr_D, pc_D} !== {imem(want_pc), want_pc}) begin
         n_fail++;
         $display("[TB] FAIL %s_target: got %h %h want %h %h", name, instr_D, pc_D, imem(want_pc), want_pc);
      end
   endtask

   task automatic test_jumps();
      do_reset();
      advance_to_pcd(32'h3020);
      npc_sel = 2; imm26_D = 26'h0000C10;
      tick();
      n_checks++;
      if ({pc_F, instr_D} !== {32'h0000_3040, imem(32'h3024)}) begin
         n_fail++;
         $display("[TB] FAIL jump_j: got %h %h want %h %h", pc_F, instr_D, 32'h3040, imem(32'h3024));
      end
      npc_sel = 3; rs_val_D = 32'h0000_3103;
      tick();
      n_checks++;
      if (pc_F !== 32'h0000_3100) begin
         n_fail++;
         $display("[TB] FAIL jump_jr: got %h want %h", pc_F, 32'h3100);
      end
      set_idle();
   endtask

   task automatic test_stall_clear();
      logic [31:0] p, i, d;
      do_reset();
      advance_to_pcd(32'h3008);
      p = pc_F; i = instr_D; d = pc_D;
      stall = 1;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks++;
         if ({pc_F, instr_D, pc_D} !== {p, i, d}) begin
            n_fail++;
            $display("[TB] FAIL stall_hold_%0d: got %h %h %h want %h %h %h", k, pc_F, instr_D, pc_D, p, i, d);
         end
      end
      stall = 0;
      tick();
      n_checks++;
      if ({pc_F, instr_D, pc_D} !== {p + 32'd4, imem(p), p}) begin
         n_fail++;
         $display("[TB] FAIL stall_resume: got %h %h %h want %h %h %h", pc_F, instr_D, pc_D, p + 32'd4, imem(p), p);
      end
      p = pc_F; i = instr_D; d = pc_D;
      stall = 1; clr_D = 1;
      tick();
      n_checks++;
      if ({pc_F, instr_D, pc_D} !== {p, i, d}) begin
         n_fail++;
         $display("[TB] FAIL stall_over_clr: got %h %h %h want %h %h %h", pc_F, instr_D, pc_D, p, i, d);
      end
      stall = 0;
      tick();
      n_checks++;
      if ({pc_F, instr_D, pc_D} !== {p + 32'd4, NOP, p}) begin
         n_fail++;
         $display("[TB] FAIL clr_alone: got %h %h %h want %h %h %h", pc_F, instr_D, pc_D, p + 32'd4, NOP, p);
      end
      clr_D = 0;
   endtask

   task automatic test_stall_redirect();
      logic [31:0] p, d;
      p = pc_F; d = pc_D;
      stall = 1; npc_sel = 2; imm26_D = 26'h0000800;
      tick();
      n_checks++;
      if (pc_F !== p) begin
         n_fail++;
         $display("[TB] FAIL stall_redirect_hold: got %h want %h", pc_F, p);
      end
      stall = 0;
      tick();
      n_checks++;
      if (pc_F !== ((d & 32'hF000_0000) | 32'h0000_2000)) begin
         n_fail++;
         $display("[TB] FAIL stall_redirect_apply: got %h want %h", pc_F, (d & 32'hF000_0000) | 32'h2000);
      end
      set_idle();
   endtask

   task automatic test_wrap();
      npc_sel = 3; rs_val_D = 32'hFFFF_FFFF;
      tick();
      n_checks++;
      if (pc_F !== 32'hFFFF_FFFC) begin
         n_fail++;
         $display("[TB] FAIL wrap_jr: got %h want %h", pc_F, 32'hFFFF_FFFC);
      end
      set_idle();
      tick();
      n_checks++;
      if ({pc_F, pc_D, pc8_D} !== {32'h0, 32'hFFFF_FFFC, 32'h4}) begin
         n_fail++;
         $display("[TB] FAIL wrap_seq: got %h %h %h want %h %h %h", pc_F, pc_D, pc8_D, 32'h0, 32'hFFFF_FFFC, 32'h4);
      end
   endtask

   task automatic test_async_reset();
      advance_to_pcd(32'h0000_0008);
      #2;
      reset = 0;
      #1;
      n_checks++;
      if ({pc_F, instr_D, pc_D, pc8_D} !== {RESET_PC, NOP, RESET_PC, RESET_PC + 32'd8}) begin
         n_fail++;
         $display("[TB] FAIL async_reset: got %h %h %h %h want %h %h %h %h",
                  pc_F, instr_D, pc_D, pc8_D, RESET_PC, NOP, RESET_PC, RESET_PC + 32'd8);
      end
      m_pc = RESET_PC; m_pcd = RESET_PC; m_instr = NOP;
      reset = 1;
   endtask

   task automatic test_random();
      int errs = 0;
      for (int c = 0; c < 400; c++) begin
         stall    = ($urandom_range(0, 3) == 0);
         clr_D    = ($urandom_range(0, 4) == 0);
         npc_sel  = 2'($urandom_range(0, 3));
         imm16_D  = 16'($urandom);
         imm26_D  = 26'($urandom);
         rs_val_D = $urandom;
         tick();
         n_checks++;
         if ({pc_F, instr_D, pc_D, pc8_D} !== {m_pc, m_instr, m_pcd, m_pcd + 32'd8}) begin
            n_fail++;
            errs++;
            if (errs < 10)
               $display("[TB] FAIL random_c%0d: got %h %h %h %h want %h %h %h %h", c,
                        pc_F, instr_D, pc_D, pc8_D, m_pc, m_instr, m_pcd, m_pcd + 32'd8);
         end
      end
      set_idle();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      set_idle();
      reset = 1;
      #1;
      test_reset();
      test_sequential();
      test_branch(16'hFFFC, 32'h0000_3004, "branch_back");
      test_branch(16'h0002, 32'h0000_301C, "branch_fwd");
      test_jumps();
      test_stall_clear();
      test_stall_redirect();
      test_wrap();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
